scan_7seg_2dig: RTL

//  Downstream display stage for the two-digit adder/BCD split (decenas, unidades).

---
 rtl/scan_7seg_2dig.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/scan_7seg_2dig.sv
// Two-digit multiplexed 7-segment driver.
// Latches BCD digits on load and scans them with a blanking gap.
module scan_7seg_2dig #(
  parameter int REFRESH_CYCLES = 1000,
  parameter int DEAD_CYCLES    = 16,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] decenas,
  input  logic [3:0] unidades,
  output logic [0:6] seg,
  output logic [1:0] dig_en,
  output logic       busy
);

  localparam int CMAX =
    (REFRESH_CYCLES > DEAD_CYCLES) ?
    REFRESH_CYCLES : DEAD_CYCLES;
  localparam int CW =
    (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] R_LAST =
    CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST =
    (DEAD_CYCLES > 0) ?
    CW'(DEAD_CYCLES - 1) : '0;
  localparam bit HAS_GAP =
    (DEAD_CYCLES > 0);

  localparam logic [0:6] SEG_OFF =
    {7{ACTIVE_LOW}};
  localparam logic [1:0] EN_OFF =
    {2{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    SHOW_U,
    GAP_U,
    SHOW_D,
    GAP_D
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dig_u_q, dig_u_d;
  logic [3:0]    dig_d_q, dig_d_d;
  logic          busy_q, busy_d;
  logic [0:6]    seg_q, seg_d;
  logic [1:0]    en_q, en_d;
  logic [0:6]    seg_hi;
  logic [1:0]    en_hi;

  // Active-high segment pattern, a..g.
  function automatic logic [0:6] decode(
    input logic [3:0] v
  );
    logic [0:6] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Digit capture; load may be held to re-capture every cycle.
  always_comb begin
    dig_u_d = dig_u_q;
    dig_d_d = dig_d_q;
    busy_d  = busy_q;
    if (load) begin
      dig_u_d = unidades;
      dig_d_d = decenas;
      busy_d  = 1'b1;
    end
  end

  // Scan sequencer: slot counter and state advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      SHOW_U: begin
        if (cnt_q == R_LAST) begin
          cnt_d   = '0;
          state_d = HAS_GAP ? GAP_U : SHOW_D;
        end
      end
      GAP_U: begin
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = SHOW_D;
        end
      end
      SHOW_D: begin
        if (cnt_q == R_LAST) begin
          cnt_d   = '0;
          state_d = HAS_GAP ? GAP_D : SHOW_U;
        end
      end
      GAP_D: begin
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = SHOW_U;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SHOW_U;
      end
    endcase
  end

  // Output pattern from current slot and freshly captured digits,
  // so a load shows up on the very next edge.
  always_comb begin
    seg_hi = '0;
    en_hi  = '0;
    if (busy_d) begin
      unique case (state_q)
        SHOW_U: begin
          en_hi  = 2'b01;
          seg_hi = decode(dig_u_d);
        end
        SHOW_D: begin
          if (!(BLANK_LZ && dig_d_d == 4'd0)) begin
            en_hi  = 2'b10;
            seg_hi = decode(dig_d_d);
          end
        end
        default: begin
          en_hi  = '0;
          seg_hi = '0;
        end
      endcase
    end
    seg_d = seg_hi ^ SEG_OFF;
    en_d  = en_hi ^ EN_OFF;
  end

  // Scan state and slot counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHOW_U;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Digit and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_u_q <= '0;
      dig_d_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      dig_u_q <= dig_u_d;
      dig_d_q <= dig_d_d;
      busy_q  <= busy_d;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      en_q  <= EN_OFF;
    end else begin
      seg_q <= seg_d;
      en_q  <= en_d;
    end
  end

  assign seg    = seg_q;
  assign dig_en = en_q;
  assign busy   = busy_q;

endmodule
